alu_decoder: RTL and testbench
==============================

# alu_decoder

Operand-select and staging register in front of the 16-bit ALU. Each enabled cycle it captures operand A from register-file port `rs`. It captures operand B from either register-file port `rq` or the instruction's sign-extended 8-bit immediate `offset`. Both operands are presented to the ALU as registered outputs. It sits between the register file / instruction decode stage and the ALU datapath.

## Interface
- `DATA_W`, 16: operand and register width.
- `OFF_W`, 8: immediate width; must satisfy `OFF_W <= DATA_W`.
- `clk` input 1: single system clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- `rs` input DATA_W: source register value, always the operand-A source.
- `rq` input DATA_W: second register value, operand-B source when `alu_in_sel`=1.
- `offset` input OFF_W: signed immediate, operand-B source when `alu_in_sel`=0.
- `en_in` input 1: capture enable; when high, operands are loaded on the next rising edge.
- `alu_in_sel` input 1: operand-B select; 1 = `rq`, 0 = sign-extended `offset`.
- `op_a` output DATA_W: registered operand A.
- `op_b` output DATA_W: registered operand B.

## Operation
- Immediate extension: `imm_ext = {{(DATA_W-OFF_W){offset[OFF_W-1]}}, offset}`. This is two's-complement sign extension with no zero-extension mode.
- B mux, combinational: `b_next = alu_in_sel ? rq : imm_ext`.
- When `rst`=0, `op_a` and `op_b` are forced to 0 immediately, independent of `clk`.
- On a rising edge with `rst`=1 and `en_in`=1, `op_a <= rs` and `op_b <= b_next`.
- On a rising edge with `rst`=1 and `en_in`=0, both outputs hold their previous values.
- A and B always load together; there is no partial update.
- No arithmetic is performed; values pass through bit-exact apart from the extension.
- Inputs are sampled only at the clock edge. Changes on `rs`, `rq`, `offset` or `alu_in_sel` between edges have no effect on the outputs.

## Timing
- Reset value: `op_a`=0 and `op_b`=0.
- Reset assertion clears the outputs asynchronously, including mid-operation, and overrides `en_in`.
- Reset deassertion is synchronous to use. The first load can occur on the first rising edge at which `rst`=1 and `en_in`=1.
- Latency: 1 cycle. Inputs present at edge N with `en_in`=1 are visible on `op_a`/`op_b` after edge N.
- No handshake; `en_in` is a level-sensitive, per-cycle enable.
- If `alu_in_sel` and `offset` change in the same cycle, the values at the capturing edge determine `op_b`.
- `offset` MSB=1 produces upper bits all ones. `offset` = 0x80 yields 0xFF80; `offset` = 0x7F yields 0x007F.

## Structure
- Shared package holds `DATA_W`=16, `OFF_W`=8 defaults, and a `ALU_SEL_REG`=1'b1 / `ALU_SEL_IMM`=1'b0 constant pair used by the decoder that drives `alu_in_sel`.
- One natural sub-module, `sign_extend`, parameterized on OFF_W→DATA_W and reused by branch/address logic.
- Remainder is a single always block with an async-low reset, plus the B mux.

## Test plan
- Hold `rst`=0 for 2 cycles with `rs`=0x2182, `rq`=0x049D, `en_in`=0 -> `op_a`=0x0000, `op_b`=0x0000 throughout.
- Release `rst`, keep `en_in`=0 for 2 cycles -> outputs remain 0x0000 and 0x0000.
- Set `en_in`=1, `alu_in_sel`=1 -> after next edge, `op_a`=0x2182 and `op_b`=0x049D.
- Set `alu_in_sel`=0, `offset`=0x24 -> after next edge, `op_a`=0x2182 and `op_b`=0x0024.
- Set `offset`=0x94 -> after next edge, `op_b`=0xFF94 (sign-extended); then drop `en_in` and change `rs`=0x1234 -> outputs hold 0x2182 and 0xFF94.
- Pulse `rst`=0 mid-cycle while `en_in`=1 -> outputs go to 0 without waiting for a clock edge. After release, the next enabled edge reloads the current inputs.

Source files
------------

// File: rtl/alu_decoder_pkg.sv
// Shared constants for the ALU operand stage.
//   ALU_DATA_W / ALU_OFF_W : default operand and immediate widths
//   alu_sel_e              : operand-B select encoding driven by the decoder
package alu_decoder_pkg;

    localparam int unsigned ALU_DATA_W = 16;
    localparam int unsigned ALU_OFF_W  = 8;

    // Operand-B source select: register port or sign-extended immediate
    typedef enum logic {
        ALU_SEL_IMM = 1'b0,
        ALU_SEL_REG = 1'b1
    } alu_sel_e;

endpackage : alu_decoder_pkg

// File: rtl/alu_decoder_if.sv
// Operand bus between register file / decode and the ALU operand stage.
//   master : decode side, drives sources and controls, observes operands
//   slave  : operand stage, consumes sources, drives registered operands
interface alu_decoder_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned OFF_W  = 8
);
    logic [DATA_W-1:0] rs;
    logic [DATA_W-1:0] rq;
    logic [OFF_W-1:0]  offset;
    logic              en_in;
    logic              alu_in_sel;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    modport master (
        output rs, rq, offset, en_in, alu_in_sel,
        input  op_a, op_b
    );

    modport slave (
        input  rs, rq, offset, en_in, alu_in_sel,
        output op_a, op_b
    );

endinterface : alu_decoder_if

// File: rtl/alu_decoder_sign_extend.sv
// Two's-complement sign extension from IN_W to OUT_W bits (combinational).
//   din    : signed value, IN_W bits
//   dout_c : sign-extended value, OUT_W bits
// Intended for IN_W <= OUT_W; a wider input is truncated to its low bits.
module sign_extend #(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned OUT_W = 16
) (
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout_c
);

    generate
        if (IN_W < OUT_W) begin : g_extend
            assign dout_c = {{(OUT_W - IN_W){din[IN_W-1]}}, din};
        end else begin : g_pass
            // Equal widths need no replication; a zero-width repeat is illegal
            assign dout_c = din[OUT_W-1:0];
        end
    endgenerate

endmodule : sign_extend

// File: rtl/alu_decoder.sv
// Operand-select and staging register in front of the ALU.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset, clears both operands
//   bus  : operand bus (slave side)
//          rs          -> op_a source
//          rq / offset -> op_b source, chosen by alu_in_sel (1 = rq)
//          en_in       -> per-cycle capture enable, A and B load together
//          op_a, op_b  -> registered operands
module alu_decoder
    import alu_decoder_pkg::*;
#(
    parameter int unsigned DATA_W = ALU_DATA_W,
    parameter int unsigned OFF_W  = ALU_OFF_W
) (
    input  logic          clk,
    input  logic          rst,
    alu_decoder_if.slave  bus
);

    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] b_next;
    logic [DATA_W-1:0] op_a_q;
    logic [DATA_W-1:0] op_b_q;

    // Immediate is always treated as signed
    sign_extend #(
        .IN_W  (OFF_W),
        .OUT_W (DATA_W)
    ) u_sign_extend (
        .din    (bus.offset),
        .dout_c (imm_ext)
    );

    // Operand-B source select
    always_comb begin
        b_next = imm_ext;
        if (bus.alu_in_sel == ALU_SEL_REG) begin
            b_next = bus.rq;
        end
    end

    // Operand staging register; reset overrides enable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_a_q <= '0;
            op_b_q <= '0;
        end else if (bus.en_in) begin
            op_a_q <= bus.rs;
            op_b_q <= b_next;
        end
    end

    assign bus.op_a = op_a_q;
    assign bus.op_b = op_b_q;

endmodule : alu_decoder

// File: tb/tb_alu_decoder.sv
// Scoreboard bench for alu_decoder: the driver queues expected operands,
// the monitor pops and compares after each clock edge or reset assertion.
module tb_alu_decoder;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        int          id;
    } exp_t;

    logic clk;
    logic rst;

    exp_t exp_q[$];
    int   n_total;
    int   n_pass;

    alu_decoder_if #(.DATA_W(16), .OFF_W(8)) bus ();

    alu_decoder #(
        .DATA_W (16),
        .OFF_W  (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Queue one expectation for the coming rising edge
    task automatic expect_next(input int id, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        e.a  = a;
        e.b  = b;
        e.id = id;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of stimulus at the falling edge and queue its result
    task automatic drive(input int id, input logic rst_v, input logic en,
                         input logic sel, input logic [15:0] rs_v,
                         input logic [15:0] rq_v, input logic [7:0] off_v,
                         input logic [15:0] ea, input logic [15:0] eb);
        @(negedge clk);
        rst            = rst_v;
        bus.en_in      = en;
        bus.alu_in_sel = sel;
        bus.rs         = rs_v;
        bus.rq         = rq_v;
        bus.offset     = off_v;
        expect_next(id, ea, eb);
    endtask

    // Monitor: compare after every edge or reset assertion that has an expectation
    always begin
        @(posedge clk or negedge rst);
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_total++;
            if (bus.op_a === e.a) n_pass++;
            else $display("FAIL vec%0d op_a: got %h expected %h", e.id, bus.op_a, e.a);
            n_total++;
            if (bus.op_b === e.b) n_pass++;
            else $display("FAIL vec%0d op_b: got %h expected %h", e.id, bus.op_b, e.b);
        end
    end

    initial begin
        n_total        = 0;
        n_pass         = 0;
        rst            = 1'b0;
        bus.en_in      = 1'b0;
        bus.alu_in_sel = 1'b0;
        bus.rs         = 16'h2182;
        bus.rq         = 16'h049D;
        bus.offset     = 8'h00;

        // Held in reset, enable low
        drive(1,  1'b0, 1'b0, 1'b1, 16'h2182, 16'h049D, 8'h00, 16'h0000, 16'h0000);
        drive(2,  1'b0, 1'b0, 1'b1, 16'h2182, 16'h049D, 8'h00, 16'h0000, 16'h0000);
        // Out of reset, still disabled
        drive(3,  1'b1, 1'b0, 1'b1, 16'h2182, 16'h049D, 8'h00, 16'h0000, 16'h0000);
        drive(4,  1'b1, 1'b0, 1'b1, 16'h2182, 16'h049D, 8'h00, 16'h0000, 16'h0000);
        // Register path, then immediate path
        drive(5,  1'b1, 1'b1, 1'b1, 16'h2182, 16'h049D, 8'h00, 16'h2182, 16'h049D);
        drive(6,  1'b1, 1'b1, 1'b0, 16'h2182, 16'h049D, 8'h24, 16'h2182, 16'h0024);
        drive(7,  1'b1, 1'b1, 1'b0, 16'h2182, 16'h049D, 8'h94, 16'h2182, 16'hFF94);
        // Disabled: hold despite rs change
        drive(8,  1'b1, 1'b0, 1'b0, 16'h1234, 16'h049D, 8'h94, 16'h2182, 16'hFF94);
        // Immediate boundaries
        drive(9,  1'b1, 1'b1, 1'b1, 16'h1234, 16'hBEEF, 8'h80, 16'h1234, 16'hBEEF);
        drive(10, 1'b1, 1'b1, 1'b0, 16'h1234, 16'hBEEF, 8'h80, 16'h1234, 16'hFF80);
        drive(11, 1'b1, 1'b1, 1'b0, 16'hFFFF, 16'hBEEF, 8'h7F, 16'hFFFF, 16'h007F);
        drive(12, 1'b1, 1'b1, 1'b0, 16'h0000, 16'hBEEF, 8'hFF, 16'h0000, 16'hFFFF);
        drive(13, 1'b1, 1'b1, 1'b0, 16'h0000, 16'hBEEF, 8'h00, 16'h0000, 16'h0000);
        // Select and offset change together; edge values win
        drive(14, 1'b1, 1'b1, 1'b1, 16'h5A5A, 16'hA5A5, 8'hC0, 16'h5A5A, 16'hA5A5);
        // Inputs wiggle between edges while disabled: no effect
        @(posedge clk);
        #2;
        bus.rs         = 16'h1111;
        bus.rq         = 16'h2222;
        bus.alu_in_sel = 1'b0;
        drive(15, 1'b1, 1'b0, 1'b0, 16'h3333, 16'h4444, 8'h81, 16'h5A5A, 16'hA5A5);

        // Load, then assert reset mid-cycle with enable high
        drive(16, 1'b1, 1'b1, 1'b1, 16'h3C3C, 16'hC3C3, 8'h00, 16'h3C3C, 16'hC3C3);
        @(negedge clk);
        #2;
        expect_next(17, 16'h0000, 16'h0000);
        rst = 1'b0;
        #2;
        rst = 1'b1;
        // Next enabled edge reloads current inputs
        expect_next(18, 16'h3C3C, 16'hC3C3);

        // Reset held across an enabled edge overrides enable
        drive(19, 1'b0, 1'b1, 1'b0, 16'h7777, 16'h8888, 8'h80, 16'h0000, 16'h0000);
        drive(20, 1'b1, 1'b1, 1'b0, 16'h7777, 16'h8888, 8'h80, 16'h7777, 16'hFF80);

        // Bounded drain of outstanding expectations
        repeat (3) @(negedge clk);
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_alu_decoder
